// File: rtl/fb_wr_if.sv
// fb_wr_if - pixel write port into the scan-out framebuffer.
//   cpu_wr   : write strobe, one byte per cycle when high
//   cpu_addr : linear pixel address (y*H_ACTIVE + x)
//   cpu_data : pixel intensity
// master = the renderer driving writes, slave = fb_scanout.
interface fb_wr_if;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_data;

    modport master (output cpu_wr, output cpu_addr, output cpu_data);
    modport slave  (input  cpu_wr, input  cpu_addr, input  cpu_data);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout - byte-per-pixel framebuffer with VGA raster scan-out.
//
// Writes arrive on the fb_wr_if slave port and land in an internal RAM
// (no back-pressure, out-of-range addresses dropped). The raster side runs
// h/v counters, reads the RAM in raster order through a synchronous read
// and drives grayscale video with sync/blank/DE, all registered and aligned
// two cycles after the counters.
//
// Ports:
//   pclk, reset_n        pixel clock, async active-low reset
//   wr (fb_wr_if.slave)  cpu_wr / cpu_addr / cpu_data pixel writes
//   hs, vs               syncs, active low
//   r, g, b              video, all equal, 0 in blank
//   VGA_HB, VGA_VB       horizontal / vertical blank, active high
//   VGA_DE               active video
//   wr_drop_cnt          (FB_SCANOUT_DROP_CNT_EN only) saturating count of
//                        dropped out-of-range writes
//
// Build option: define FB_SCANOUT_DROP_CNT_EN to add wr_drop_cnt.
module fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_DEPTH = H_ACTIVE * V_ACTIVE
) (
    input  logic       pclk,
    input  logic       reset_n,
    fb_wr_if.slave     wr,
    output logic       hs,
    output logic       vs,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       VGA_HB,
    output logic       VGA_VB,
    output logic       VGA_DE
`ifdef FB_SCANOUT_DROP_CNT_EN
    ,
    output logic [15:0] wr_drop_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FB_DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [31:0]   FB_LIMIT = 32'(FB_DEPTH);

    // ---------------- write side ----------------
    logic [7:0]    mem [FB_DEPTH];
    logic          in_range;
    logic [AW-1:0] wr_addr;

    assign in_range = wr.cpu_addr < FB_LIMIT;
    assign wr_addr  = wr.cpu_addr[AW-1:0];

    // ---------------- raster counters ----------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] rd_addr;
    logic          frame_end;

    // Stage-0 decode straight off the counters
    logic hb0, vb0, hs0, vs0;
    assign hb0       = h_cnt >= H_ACT;
    assign vb0       = v_cnt >= V_ACT;
    assign hs0       = !(h_cnt >= HS_BEG && h_cnt <= HS_END);
    assign vs0       = !(v_cnt >= VS_BEG && v_cnt <= VS_END);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            rd_addr <= '0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            // Raster-order address tracked incrementally; it only advances on
            // visible pixels so it equals y*H_ACTIVE+x without a multiplier.
            if (frame_end)
                rd_addr <= '0;
            else if (!hb0 && !vb0)
                rd_addr <= rd_addr + AW'(1);
        end
    end

    // ---------------- stage 1: RAM read + decode register ----------------
    // Write and read in one block with non-blocking semantics: a read of the
    // address being written this cycle sees the old byte.
    logic [7:0] ram_q;

    always_ff @(posedge pclk) begin
        if (wr.cpu_wr && in_range)
            mem[wr_addr] <= wr.cpu_data;
        ram_q <= mem[rd_addr];
    end

    logic hb1, vb1, hs1, vs1;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hb1 <= 1'b1;
            vb1 <= 1'b1;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
        end else begin
            hb1 <= hb0;
            vb1 <= vb0;
            hs1 <= hs0;
            vs1 <= vs0;
        end
    end

    // ---------------- stage 2: output register ----------------
    logic [7:0] pix;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs     <= 1'b1;
            vs     <= 1'b1;
            VGA_HB <= 1'b1;
            VGA_VB <= 1'b1;
            VGA_DE <= 1'b0;
            pix    <= '0;
        end else begin
            hs     <= hs1;
            vs     <= vs1;
            VGA_HB <= hb1;
            VGA_VB <= vb1;
            VGA_DE <= !hb1 && !vb1;
            // RAM contents outside the visible area are never shown
            pix    <= (!hb1 && !vb1) ? ram_q : 8'h00;
        end
    end

    assign r = pix;
    assign g = pix;
    assign b = pix;

`ifdef FB_SCANOUT_DROP_CNT_EN
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n)
            wr_drop_cnt <= '0;
        else if (wr.cpu_wr && !in_range && wr_drop_cnt != 16'hFFFF)
            wr_drop_cnt <= wr_drop_cnt + 16'd1;
    end
`endif

endmodule
